// File: rtl/decoder_10b8b_sync.sv
// decoder_10b8b_sync: 8b/10b receive decoder with running-disparity tracking,
// code/disparity violation flags and a comma-based word-sync state machine.
// Stage 1 registers the raw symbol; stage 2 decodes, checks and registers.
module decoder_10b8b_sync #(
  parameter int COMMAS_TO_SYNC = 3,
  parameter int ERRS_TO_LOSE   = 4,
  parameter int GOOD_TO_DECR   = 16
) (
  input  logic       SBYTECLK,
  input  logic       RESET,
  input  logic [9:0] i_data10b,
  input  logic       i_valid,
  output logic [7:0] o_data8b,
  output logic       o_K,
  output logic       o_valid,
  output logic       o_code_err,
  output logic       o_disp_err,
  output logic       o_rd,
  output logic       o_sync
);

  localparam int CCW = $clog2(COMMAS_TO_SYNC + 1);
  localparam int ECW = $clog2(ERRS_TO_LOSE + 1);
  localparam int GCW = $clog2(GOOD_TO_DECR + 1);

  typedef enum logic {UNSYNC = 1'b0, SYNC = 1'b1} state_e;

  // 5b/6b data table (abcdei); K28 patterns handled separately. {legal, x}
  function automatic logic [5:0] dec6(input logic [5:0] s);
    case (s)
      6'b100111, 6'b011000: dec6 = {1'b1, 5'd0};
      6'b011101, 6'b100010: dec6 = {1'b1, 5'd1};
      6'b101101, 6'b010010: dec6 = {1'b1, 5'd2};
      6'b110001:            dec6 = {1'b1, 5'd3};
      6'b110101, 6'b001010: dec6 = {1'b1, 5'd4};
      6'b101001:            dec6 = {1'b1, 5'd5};
      6'b011001:            dec6 = {1'b1, 5'd6};
      6'b111000, 6'b000111: dec6 = {1'b1, 5'd7};
      6'b111001, 6'b000110: dec6 = {1'b1, 5'd8};
      6'b100101:            dec6 = {1'b1, 5'd9};
      6'b010101:            dec6 = {1'b1, 5'd10};
      6'b110100:            dec6 = {1'b1, 5'd11};
      6'b001101:            dec6 = {1'b1, 5'd12};
      6'b101100:            dec6 = {1'b1, 5'd13};
      6'b011100:            dec6 = {1'b1, 5'd14};
      6'b010111, 6'b101000: dec6 = {1'b1, 5'd15};
      6'b011011, 6'b100100: dec6 = {1'b1, 5'd16};
      6'b100011:            dec6 = {1'b1, 5'd17};
      6'b010011:            dec6 = {1'b1, 5'd18};
      6'b110010:            dec6 = {1'b1, 5'd19};
      6'b001011:            dec6 = {1'b1, 5'd20};
      6'b101010:            dec6 = {1'b1, 5'd21};
      6'b011010:            dec6 = {1'b1, 5'd22};
      6'b111010, 6'b000101: dec6 = {1'b1, 5'd23};
      6'b110011, 6'b001100: dec6 = {1'b1, 5'd24};
      6'b100110:            dec6 = {1'b1, 5'd25};
      6'b010110:            dec6 = {1'b1, 5'd26};
      6'b110110, 6'b001001: dec6 = {1'b1, 5'd27};
      6'b001110:            dec6 = {1'b1, 5'd28};
      6'b101110, 6'b010001: dec6 = {1'b1, 5'd29};
      6'b011110, 6'b100001: dec6 = {1'b1, 5'd30};
      6'b101011, 6'b010100: dec6 = {1'b1, 5'd31};
      default:              dec6 = 6'd0;
    endcase
  endfunction

  // 3b/4b data table (fghj), both P7 and A7 forms of y=7. {legal, y}
  function automatic logic [3:0] dec4(input logic [3:0] s);
    case (s)
      4'b1011, 4'b0100:                   dec4 = {1'b1, 3'd0};
      4'b1001:                            dec4 = {1'b1, 3'd1};
      4'b0101:                            dec4 = {1'b1, 3'd2};
      4'b1100, 4'b0011:                   dec4 = {1'b1, 3'd3};
      4'b1101, 4'b0010:                   dec4 = {1'b1, 3'd4};
      4'b1010:                            dec4 = {1'b1, 3'd5};
      4'b0110:                            dec4 = {1'b1, 3'd6};
      4'b1110, 4'b0001, 4'b0111, 4'b1000: dec4 = {1'b1, 3'd7};
      default:                            dec4 = 4'd0;
    endcase
  endfunction

  // K28 fghj, normalised to the form that follows 001111. {legal, y}
  function automatic logic [3:0] deck28(input logic [3:0] s);
    case (s)
      4'b0100: deck28 = {1'b1, 3'd0};
      4'b1001: deck28 = {1'b1, 3'd1};
      4'b0101: deck28 = {1'b1, 3'd2};
      4'b0011: deck28 = {1'b1, 3'd3};
      4'b0010: deck28 = {1'b1, 3'd4};
      4'b1010: deck28 = {1'b1, 3'd5};
      4'b0110: deck28 = {1'b1, 3'd6};
      4'b1000: deck28 = {1'b1, 3'd7};
      default: deck28 = 4'd0;
    endcase
  endfunction

  function automatic logic [2:0] ones(input logic [5:0] s);
    ones = 3'd0;
    for (int i = 0; i < 6; i++) ones = ones + {2'b00, s[i]};
  endfunction

  logic [9:0]     sym_p1_q;
  logic           vld_p1_q, vld_p2_q;
  logic [7:0]     byte_p2_q;
  logic           k_p2_q, cerr_p2_q, derr_p2_q;
  logic           rd_q;
  state_e         state_q, state_d;
  logic [CCW-1:0] comma_q, comma_d;
  logic [ECW-1:0] errs_q, errs_d;
  logic [GCW-1:0] good_q, good_d;

  logic [5:0] sb6, r6;
  logic [3:0] sb4, fk, r4, rk;
  logic [2:0] n6, n4;
  logic       pos6, neg6, pos4, neg4, k28, a7;
  logic       legal, k_flag, rd6, rd_nxt, code_err, disp_err, comma;
  logic [4:0] x;
  logic [2:0] y;

  // Stage 1: capture raw symbol and its valid.
  always_ff @(posedge SBYTECLK) begin
    sym_p1_q <= i_data10b;
    if (RESET) vld_p1_q <= 1'b0;
    else       vld_p1_q <= i_valid;
  end

  // Stage 2 combinational: table lookups, legality, disparity and RD chain.
  always_comb begin
    sb6    = sym_p1_q[9:4];
    sb4    = sym_p1_q[3:0];
    n6     = ones(sb6);
    n4     = ones({2'b00, sb4});
    pos6   = (n6 == 3'd4);
    neg6   = (n6 == 3'd2);
    pos4   = (n4 == 3'd3);
    neg4   = (n4 == 3'd1);
    k28    = (sb6 == 6'b001111) || (sb6 == 6'b110000);
    fk     = (sb6 == 6'b110000) ? ~sb4 : sb4;
    r6     = dec6(sb6);
    r4     = dec4(sb4);
    rk     = deck28(fk);
    a7     = (sb4 == 4'b0111) || (sb4 == 4'b1000);
    legal  = 1'b0;
    k_flag = 1'b0;
    x      = r6[4:0];
    y      = r4[2:0];
    if (k28) begin
      legal  = rk[3];
      k_flag = 1'b1;
      x      = 5'd28;
      y      = rk[2:0];
    end else if (r6[5] && r4[3]) begin
      if (!a7) begin
        legal = 1'b1;
      end else if ((sb4 == 4'b0111 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                   (sb4 == 4'b1000 && (x == 5'd11 || x == 5'd13 || x == 5'd14))) begin
        legal = 1'b1;
      end else if ((x == 5'd23 || x == 5'd27 || x == 5'd29 || x == 5'd30) &&
                   ((pos6 && sb4 == 4'b1000) || (neg6 && sb4 == 4'b0111))) begin
        legal  = 1'b1;
        k_flag = 1'b1;
      end
    end
    // Neutral special patterns only steer RD on a legal codeword.
    if (pos6)                            rd6 = 1'b1;
    else if (neg6)                       rd6 = 1'b0;
    else if (legal && sb6 == 6'b111000)  rd6 = 1'b1;
    else if (legal && sb6 == 6'b000111)  rd6 = 1'b0;
    else                                 rd6 = rd_q;
    if (pos4)                            rd_nxt = 1'b1;
    else if (neg4)                       rd_nxt = 1'b0;
    else if (legal && sb4 == 4'b1100)    rd_nxt = 1'b1;
    else if (legal && sb4 == 4'b0011)    rd_nxt = 1'b0;
    else                                 rd_nxt = rd6;
    code_err = !legal;
    disp_err = legal && ((pos6 && rd_q) || (neg6 && !rd_q) || (pos4 && rd6) || (neg4 && !rd6));
    comma    = legal && !disp_err && k28 && (rk[2:0] == 3'd5);
  end

  // Sync FSM next state, advanced once per decoded symbol.
  always_comb begin
    state_d = state_q;
    comma_d = comma_q;
    errs_d  = errs_q;
    good_d  = good_q;
    if (vld_p1_q) begin
      case (state_q)
        UNSYNC: begin
          if (code_err || disp_err) begin
            comma_d = '0;
          end else if (comma) begin
            if (comma_q == CCW'(COMMAS_TO_SYNC - 1)) begin
              state_d = SYNC;
              comma_d = '0;
              errs_d  = '0;
              good_d  = '0;
            end else begin
              comma_d = comma_q + 1'b1;
            end
          end
        end
        SYNC: begin
          if (code_err || disp_err) begin
            good_d = '0;
            if (errs_q == ECW'(ERRS_TO_LOSE - 1)) begin
              state_d = UNSYNC;
              comma_d = '0;
              errs_d  = '0;
            end else begin
              errs_d = errs_q + 1'b1;
            end
          end else if (good_q == GCW'(GOOD_TO_DECR - 1)) begin
            good_d = '0;
            if (errs_q != '0) errs_d = errs_q - 1'b1;
          end else begin
            good_d = good_q + 1'b1;
          end
        end
        default: state_d = UNSYNC;
      endcase
    end
  end

  // Stage 2: register decoded outputs, RD and sync state.
  always_ff @(posedge SBYTECLK) begin
    if (RESET) begin
      vld_p2_q  <= 1'b0;
      byte_p2_q <= 8'h00;
      k_p2_q    <= 1'b0;
      cerr_p2_q <= 1'b0;
      derr_p2_q <= 1'b0;
      rd_q      <= 1'b0;
      state_q   <= UNSYNC;
      comma_q   <= '0;
      errs_q    <= '0;
      good_q    <= '0;
    end else begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        byte_p2_q <= legal ? {y, x} : 8'h00;
        k_p2_q    <= legal && k_flag;
        cerr_p2_q <= code_err;
        derr_p2_q <= disp_err;
        rd_q      <= rd_nxt;
      end
      state_q <= state_d;
      comma_q <= comma_d;
      errs_q  <= errs_d;
      good_q  <= good_d;
    end
  end

  assign o_valid    = vld_p2_q;
  assign o_data8b   = byte_p2_q;
  assign o_K        = k_p2_q;
  assign o_code_err = cerr_p2_q;
  assign o_disp_err = derr_p2_q;
  assign o_rd       = rd_q;
  assign o_sync     = (state_q == SYNC);

endmodule

// File: tb/tb_decoder_10b8b_sync.sv
// Directed bench for decoder_10b8b_sync: expected outputs are queued as each
// symbol is driven and compared when o_valid presents the decoded result.
module tb_decoder_10b8b_sync;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] din;
  logic       vin;
  logic [7:0] dout;
  logic       kout, vout, cerr, derr, rdo, syo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [12:0] v;
  } exp_t;

  exp_t        sb[$];
  logic [1:0]  vhist = 2'b00;
  logic [12:0] last  = '0;

  always #5 clk = ~clk;

  decoder_10b8b_sync dut (
    .SBYTECLK  (clk),
    .RESET     (rst),
    .i_data10b (din),
    .i_valid   (vin),
    .o_data8b  (dout),
    .o_K       (kout),
    .o_valid   (vout),
    .o_code_err(cerr),
    .o_disp_err(derr),
    .o_rd      (rdo),
    .o_sync    (syo)
  );

  // Packed expectation: {data, K, code_err, disp_err, rd, sync}
  function automatic logic [12:0] pk(input logic [7:0] d, input logic k, input logic ce,
                                     input logic de, input logic rd, input logic sy);
    return {d, k, ce, de, rd, sy};
  endfunction

  task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed={d,K,ce,de,rd,sync}=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t        e;
    logic [12:0] obs;
    @(posedge clk);
    if (rst) begin
      vhist = 2'b00;
      sb.delete();
      last = '0;
    end else begin
      vhist = {vhist[0], vin};
    end
    #1;
    obs = {dout, kout, cerr, derr, rdo, syo};
    chk("o_valid", {12'd0, vout}, {12'd0, vhist[1]});
    if (vout) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_underflow observed=o_valid_1 expected=queued_entry");
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk(e.tag, obs, e.v);
        last = e.v;
      end
    end else begin
      chk(rst ? "reset_state" : "hold", obs, last);
    end
  endtask

  task automatic send(input string tag, input logic [9:0] sym, input logic [12:0] ev);
    exp_t e;
    din   = sym;
    vin   = 1'b1;
    e.tag = tag;
    e.v   = ev;
    sb.push_back(e);
    tick();
  endtask

  task automatic idle(input int n);
    vin = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    vin = 1'b0;
    din = 10'h000;
    tick();
    tick();
    rst = 1'b0;

    // Basic decode, RD tracking, disparity and code errors
    send("k28.5_rdm", 10'h0FA, pk(8'hBC, 1, 0, 0, 1, 0));
    send("k28.5_rdp", 10'h305, pk(8'hBC, 1, 0, 0, 0, 0));
    send("d0.0",      10'h274, pk(8'h00, 0, 0, 0, 0, 0));
    send("d21.5",     10'h2AA, pk(8'hB5, 0, 0, 0, 0, 0));
    send("d3.0",      10'h31B, pk(8'h03, 0, 0, 0, 1, 0));
    send("d3.0_disp", 10'h31B, pk(8'h03, 0, 0, 1, 1, 0));
    send("code_zero", 10'h000, pk(8'h00, 0, 1, 0, 1, 0));
    send("d3.0_rdp",  10'h314, pk(8'h03, 0, 0, 0, 0, 0));

    // Comma alternation into SYNC, then four errors out of it
    send("sync_c1", 10'h0FA, pk(8'hBC, 1, 0, 0, 1, 0));
    send("sync_c2", 10'h305, pk(8'hBC, 1, 0, 0, 0, 0));
    send("sync_c3", 10'h0FA, pk(8'hBC, 1, 0, 0, 1, 1));
    send("sync_c4", 10'h305, pk(8'hBC, 1, 0, 0, 0, 1));
    send("sync_c5", 10'h0FA, pk(8'hBC, 1, 0, 0, 1, 1));
    send("sync_c6", 10'h305, pk(8'hBC, 1, 0, 0, 0, 1));
    send("lose_e1", 10'h000, pk(8'h00, 0, 1, 0, 0, 1));
    send("lose_e2", 10'h000, pk(8'h00, 0, 1, 0, 0, 1));
    send("lose_e3", 10'h000, pk(8'h00, 0, 1, 0, 0, 1));
    send("lose_e4", 10'h000, pk(8'h00, 0, 1, 0, 0, 0));

    // Alternate-7 legality and K.x.7
    send("d17.a7",     10'h237, pk(8'hF1, 0, 0, 0, 1, 0));
    send("d17.a7_bad", 10'h238, pk(8'h00, 0, 1, 0, 0, 0));
    send("k23.7",      10'h3A8, pk(8'hF7, 1, 0, 0, 0, 0));

    // Back into SYNC, error count 3 -> 2 -> 3 -> 4
    send("resync_c1", 10'h0FA, pk(8'hBC, 1, 0, 0, 1, 0));
    send("resync_c2", 10'h305, pk(8'hBC, 1, 0, 0, 0, 0));
    send("resync_c3", 10'h0FA, pk(8'hBC, 1, 0, 0, 1, 1));
    send("cnt_e1", 10'h000, pk(8'h00, 0, 1, 0, 1, 1));
    send("cnt_e2", 10'h000, pk(8'h00, 0, 1, 0, 1, 1));
    send("cnt_e3", 10'h000, pk(8'h00, 0, 1, 0, 1, 1));
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) send("good_run", 10'h305, pk(8'hBC, 1, 0, 0, 0, 1));
      else            send("good_run", 10'h0FA, pk(8'hBC, 1, 0, 0, 1, 1));
    end
    send("cnt_after_decr", 10'h000, pk(8'h00, 0, 1, 0, 1, 1));
    send("cnt_lose",       10'h000, pk(8'h00, 0, 1, 0, 1, 0));

    // Valid gaps: RD and comma count hold across idle cycles
    send("gap_c1", 10'h305, pk(8'hBC, 1, 0, 0, 0, 0));
    idle(3);
    send("gap_c2", 10'h0FA, pk(8'hBC, 1, 0, 0, 1, 0));
    idle(2);
    send("gap_c3", 10'h305, pk(8'hBC, 1, 0, 0, 0, 1));
    send("pre_rst", 10'h0FA, pk(8'hBC, 1, 0, 0, 1, 1));
    idle(1);

    // Reset with a symbol in flight: flushed, RD and state cleared
    send("flushed", 10'h305, pk(8'hBC, 1, 0, 0, 0, 1));
    rst = 1'b1;
    vin = 1'b0;
    tick();
    rst = 1'b0;
    send("d3.0_post_rst", 10'h31B, pk(8'h03, 0, 0, 0, 1, 0));
    idle(3);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain observed=%0d expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
